// File: rtl/cpu_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and write-back in one clock.
// Ports: clk (rising-edge clock), rst_n (async active-low reset); state is observed hierarchically.

module cpu_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // Write port is tied off at the top; contents are normally preloaded.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

module cpu_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_nxt,
  output logic [31:0] pc
);
  logic [31:0] next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) next_pc <= RESET_PC;
    else        next_pc <= pc_nxt;
  end

  assign pc = next_pc;
endmodule

module cpu_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd,
  input  logic [31:0] wd
);
  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && rd != 5'd0) begin
      regs[rd] <= wd;
    end
  end

  assign rs1_data = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : regs[rs2];
endmodule

module cpu_dmem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module cpu_core #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [31:0] pc, pc_nxt, pc4, ir;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] rd_data, mem_addr, mem_rdata;
  logic        rd_we, mem_we;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  cpu_pc #(.RESET_PC(RESET_PC)) pc_item (
    .clk    (clk),
    .rst_n  (rst_n),
    .pc_nxt (pc_nxt),
    .pc     (pc)
  );

  cpu_imem #(.DEPTH(IMEM_DEPTH)) instr_memory_item (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (pc[IAW+1:2]),
    .rdata (ir)
  );

  cpu_regfile regfile_item (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (ir[19:15]),
    .rs2      (ir[24:20]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (rd_we),
    .rd       (ir[11:7]),
    .wd       (rd_data)
  );

  cpu_dmem #(.DEPTH(DMEM_DEPTH)) data_memory_item (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr[DAW+1:2]),
    .wdata (rs2_data),
    .rdata (mem_rdata)
  );

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];
  assign pc4 = pc + 32'd4;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  assign mem_addr = rs1_data + ((opc == OP_ST) ? imm_s : imm_i);

  function automatic logic [31:0] alu(
    input logic [2:0]  fn,
    input logic        alt,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [4:0] sh;
    sh = b[4:0];
    case (fn)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << sh;
      3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  logic br_take, op_ok, imm_ok;

  always_comb begin
    br_take = 1'b0;
    case (f3)
      3'd0: br_take = rs1_data == rs2_data;
      3'd1: br_take = rs1_data != rs2_data;
      3'd4: br_take = $signed(rs1_data) < $signed(rs2_data);
      3'd5: br_take = $signed(rs1_data) >= $signed(rs2_data);
      3'd6: br_take = rs1_data < rs2_data;
      3'd7: br_take = rs1_data >= rs2_data;
      default: br_take = 1'b0;
    endcase
  end

  // funct7 0x20 only selects SUB/SRA; other encodings fall through as NOP.
  assign op_ok = (f7 == 7'h00) ||
                 (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
  assign imm_ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                  (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) :
                  1'b1;

  always_comb begin
    rd_we   = 1'b0;
    rd_data = '0;
    mem_we  = 1'b0;
    pc_nxt  = pc4;
    unique case (1'b1)
      opc == OP_LUI: begin
        rd_we   = 1'b1;
        rd_data = imm_u;
      end
      opc == OP_AUIPC: begin
        rd_we   = 1'b1;
        rd_data = pc + imm_u;
      end
      opc == OP_JAL: begin
        rd_we   = 1'b1;
        rd_data = pc4;
        pc_nxt  = pc + imm_j;
      end
      opc == OP_JALR && f3 == 3'd0: begin
        rd_we   = 1'b1;
        rd_data = pc4;
        pc_nxt  = (rs1_data + imm_i) & ~32'd1;
      end
      opc == OP_BR && f3[2:1] != 2'b01: begin
        if (br_take) pc_nxt = pc + imm_b;
      end
      opc == OP_LD && f3 == 3'd2: begin
        rd_we   = 1'b1;
        rd_data = mem_rdata;
      end
      opc == OP_ST && f3 == 3'd2: begin
        mem_we = 1'b1;
      end
      opc == OP_IMM && imm_ok: begin
        rd_we   = 1'b1;
        rd_data = alu(f3, f3 == 3'd5 && ir[30],
                      rs1_data, imm_i);
      end
      opc == OP_REG && op_ok: begin
        rd_we   = 1'b1;
        rd_data = alu(f3, ir[30], rs1_data, rs2_data);
      end
      default: ;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{pc[31:IAW+2], pc[1:0],
                         mem_addr[31:DAW+2], mem_addr[1:0]};
endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: preloads a program, steps it one edge at a time,
// and checks PC, register file and data memory against hand-computed values.

module tb_cpu_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cpu_core dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;

  function automatic logic [31:0] ei(int imm, int rs1, int f3,
                                     int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] er(int f7, int rs2, int rs1,
                                     int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OPR};
  endfunction

  function automatic logic [31:0] es(int imm, int rs2, int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'd2, v[4:0], ST};
  endfunction

  function automatic logic [31:0] eb(int imm, int rs2, int rs1,
                                     int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            v[4:1], v[11], BR};
  endfunction

  function automatic logic [31:0] eu(int imm20, int rd,
                                     logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] ej(int imm, int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), JAL};
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] pc_exp;
    int          rd;
    logic [31:0] val;
    bit          nop;
  } vec_t;

  vec_t        vt [$];
  logic [31:0] prog [64];
  logic [31:0] snap [32];

  task automatic add(string n, logic [31:0] p, int rd,
                     logic [31:0] v, bit nop = 1'b0);
    vec_t e;
    e.name = n; e.pc_exp = p; e.rd = rd; e.val = v; e.nop = nop;
    vt.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0013;
    prog[0]  = ei(5, 0, 0, 1, OPI);
    prog[1]  = ei(6, 0, 0, 2, OPI);
    prog[2]  = er(0, 2, 1, 0, 3);
    prog[3]  = er(32, 2, 1, 0, 4);
    prog[4]  = ei(32'h401, 4, 5, 5, OPI);
    prog[5]  = ei(7, 0, 0, 0, OPI);
    prog[6]  = er(0, 0, 0, 0, 6);
    prog[7]  = eb(8, 1, 1, 0);
    prog[8]  = ei(1, 0, 0, 9, OPI);
    prog[9]  = eb(8, 1, 1, 1);
    prog[10] = es(16, 3, 0);
    prog[11] = ei(16, 0, 2, 8, LD);
    prog[12] = 32'h0000_007F;
    prog[13] = ej(8, 0);
    prog[14] = ej(12, 0);
    prog[15] = ej(-4, 7);
    prog[17] = ei(81, 0, 0, 10, OPI);
    prog[18] = ei(4, 10, 0, 11, JALR);
    prog[19] = ei(1, 0, 0, 12, OPI);
    prog[20] = ei(1, 0, 0, 12, OPI);
    prog[21] = ei(-1, 0, 0, 13, OPI);
    prog[22] = er(0, 1, 13, 2, 14);
    prog[23] = er(0, 1, 13, 3, 15);
    prog[24] = ei(0, 13, 2, 16, OPI);
    prog[25] = ei(-1, 1, 3, 17, OPI);
    prog[26] = ei(15, 1, 4, 18, OPI);
    prog[27] = ei(8, 1, 6, 19, OPI);
    prog[28] = ei(6, 3, 7, 20, OPI);
    prog[29] = ei(4, 1, 1, 21, OPI);
    prog[30] = ei(28, 13, 5, 22, OPI);
    prog[31] = er(0, 2, 1, 1, 23);
    prog[32] = er(0, 1, 13, 5, 24);
    prog[33] = er(32, 1, 13, 5, 25);
    prog[34] = er(0, 2, 1, 4, 26);
    prog[35] = er(0, 2, 1, 6, 27);
    prog[36] = er(0, 2, 1, 7, 28);
    prog[37] = eu(32'h12345, 29, LUI);
    prog[38] = eu(1, 30, AUIPC);
    prog[39] = eb(8, 1, 13, 4);
    prog[41] = eb(8, 13, 1, 5);
    prog[43] = eb(8, 13, 1, 6);
    prog[45] = eb(8, 13, 1, 7);
    prog[46] = eb(8, 13, 1, 4);
    prog[47] = er(0, 1, 1, 0, 1);

    add("addi_x1", 4, 1, 5);
    add("addi_x2", 8, 2, 6);
    add("add", 12, 3, 11);
    add("sub", 16, 4, 32'hFFFF_FFFF);
    add("srai", 20, 5, 32'hFFFF_FFFF);
    add("x0_write", 24, 0, 0);
    add("add_x0", 28, 6, 0);
    add("beq_taken", 36, 9, 0);
    add("bne_not", 40, -1, 0);
    add("sw", 44, -1, 0);
    add("lw", 48, 8, 11);
    add("illegal", 52, -1, 0, 1'b1);
    add("jal_fwd", 60, -1, 0);
    add("jal_back", 56, 7, 64);
    add("jal_x0", 68, -1, 0);
    add("addi_odd", 72, 10, 81);
    add("jalr", 84, 11, 76);
    add("addi_m1", 88, 12, 0);
    add("slt", 92, 14, 1);
    add("sltu", 96, 15, 0);
    add("slti", 100, 16, 1);
    add("sltiu", 104, 17, 1);
    add("xori", 108, 18, 10);
    add("ori", 112, 19, 13);
    add("andi", 116, 20, 2);
    add("slli", 120, 21, 80);
    add("srli", 124, 22, 15);
    add("sll", 128, 23, 320);
    add("srl", 132, 24, 32'h07FF_FFFF);
    add("sra", 136, 25, 32'hFFFF_FFFF);
    add("xor", 140, 26, 3);
    add("or", 144, 27, 7);
    add("and", 148, 28, 4);
    add("lui", 152, 29, 32'h1234_5000);
    add("auipc", 156, 30, 32'h0000_1098);
    add("blt_taken", 164, -1, 0);
    add("bge_taken", 172, -1, 0);
    add("bltu_taken", 180, -1, 0);
    add("bgeu_not", 184, -1, 0);
    add("blt_not", 188, 13, 32'hFFFF_FFFF);
    add("add_self", 192, 1, 10);

    for (int i = 0; i < 256; i++) begin
      dut.instr_memory_item.mem[i] = (i < 64) ? prog[i] : 32'h13;
      dut.data_memory_item.mem[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", dut.pc_item.next_pc, 32'h0);
    check("reset_x1", dut.regfile_item.regs[1], 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[k]) begin
      for (int r = 0; r < 32; r++) snap[r] = dut.regfile_item.regs[r];
      @(posedge clk);
      #1;
      check({vt[k].name, "_pc"}, dut.pc_item.next_pc, vt[k].pc_exp);
      if (vt[k].rd >= 0)
        check({vt[k].name, "_rd"},
              dut.regfile_item.regs[vt[k].rd], vt[k].val);
      if (vt[k].nop) begin
        int diff;
        diff = 0;
        for (int r = 0; r < 32; r++)
          if (dut.regfile_item.regs[r] !== snap[r]) diff++;
        check({vt[k].name, "_regs"}, 32'(diff), 32'd0);
        check({vt[k].name, "_mem"},
              dut.data_memory_item.mem[4], 32'd11);
      end
      if (vt[k].name == "sw")
        check("sw_mem", dut.data_memory_item.mem[4], 32'd11);
    end

    check("x12_skipped", dut.regfile_item.regs[12], 32'h0);
    check("x2_kept", dut.regfile_item.regs[2], 32'd6);

    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", dut.pc_item.next_pc, 32'h0);
    begin
      int nz;
      nz = 0;
      for (int r = 0; r < 32; r++)
        if (dut.regfile_item.regs[r] !== 32'h0) nz++;
      check("mid_rst_regs", 32'(nz), 32'd0);
    end
    check("mid_rst_imem", dut.instr_memory_item.mem[0], prog[0]);
    check("mid_rst_dmem", dut.data_memory_item.mem[4], 32'd11);

    @(posedge clk);
    #1;
    check("held_pc", dut.pc_item.next_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerun_x1", dut.regfile_item.regs[1], 32'd5);
    check("rerun_pc1", dut.pc_item.next_pc, 32'd4);
    @(posedge clk);
    #1;
    check("rerun_x2", dut.regfile_item.regs[2], 32'd6);
    check("rerun_pc2", dut.pc_item.next_pc, 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
